// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the 10-bit CPU datapath.
// Define CPU_CTRL_FAST_MOV_EN to let MOV skip RD/EX and write in cycle 1.
`timescale 1ns/1ps
module cpu_ctrl_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [9:0] instr,
    output logic       instr_ready,
    input  logic       data_valid,
    output logic       data_ack,
    output logic       rf_we,
    output logic [1:0] rf_wa,
    output logic       rf_rae,
    output logic       rf_rbe,
    output logic [1:0] rf_raa,
    output logic [1:0] rf_rba,
    output logic [2:0] alu_op,
    output logic [1:0] wsel,
    output logic [9:0] imm,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEC, S_RD, S_EX, S_WR, S_WAITD
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000, OP_MOV = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
        OP_AND  = 3'b100, OP_OR  = 3'b101, OP_LDI = 3'b110, OP_RSV = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010,
        ALU_AND    = 3'b011, ALU_OR  = 3'b100
    } alu_t;

    typedef enum logic [1:0] {
        WS_ALU = 2'b00, WS_EXT = 2'b01, WS_IMM = 2'b10
    } wsel_t;

    state_t     state, state_nx;
    logic [9:0] ir;
    opcode_t    op;
    logic [1:0] rx, ry;
    logic       is_alu, is_mov, reads_on;
    alu_t       alu_sel;

    assign op = opcode_t'(ir[9:7]);
    assign rx = ir[6:5];
    assign ry = ir[4:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && instr_valid)
                ir <= instr;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (instr_valid) state_nx = S_DEC;
            S_DEC: begin
                case (op)
                    OP_RSV:  state_nx = S_IDLE;
                    OP_LOAD: state_nx = S_WAITD;
                    OP_LDI:  state_nx = S_WR;
`ifdef CPU_CTRL_FAST_MOV_EN
                    OP_MOV:  state_nx = S_WR;
`else
                    OP_MOV:  state_nx = S_RD;
`endif
                    default: state_nx = S_RD;
                endcase
            end
            S_RD:    state_nx = S_EX;
            S_EX:    state_nx = S_WR;
            S_WR:    state_nx = S_IDLE;
            S_WAITD: if (data_valid) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        is_alu   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
        is_mov   = (op == OP_MOV);
        reads_on = state inside {S_RD, S_EX, S_WR};
        case (op)
            OP_ADD:  alu_sel = ALU_ADD;
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            default: alu_sel = ALU_PASS_B;
        endcase
    end

    // Read ports stay enabled into WR so the ALU result is still valid at the write.
    always_comb begin
        instr_ready = (state == S_IDLE);
        data_ack    = 1'b0;
        rf_we       = 1'b0;
        rf_wa       = '0;
        rf_rae      = 1'b0;
        rf_rbe      = 1'b0;
        rf_raa      = '0;
        rf_rba      = '0;
        alu_op      = ALU_PASS_B;
        wsel        = WS_ALU;
        imm         = '0;
        done        = 1'b0;
        illegal     = 1'b0;

        if (reads_on && (is_alu || is_mov)) begin
            rf_rbe = 1'b1;
            rf_rba = ry;
            alu_op = alu_sel;
            if (is_alu) begin
                rf_rae = 1'b1;
                rf_raa = rx;
            end
        end

        case (state)
            S_DEC: illegal = (op == OP_RSV);
            S_WR: begin
                rf_we = 1'b1;
                rf_wa = rx;
                done  = 1'b1;
                if (op == OP_LDI) begin
                    wsel = WS_IMM;
                    imm  = {7'b0, ir[2:0]};
                end
            end
            S_WAITD: begin
                wsel = WS_EXT;
                if (data_valid) begin
                    rf_we    = 1'b1;
                    rf_wa    = rx;
                    data_ack = 1'b1;
                    done     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: vector table, hand-written corner cases, random traffic.
// Honours CPU_CTRL_FAST_MOV_EN for the expected MOV write cycle.
`timescale 1ns/1ps
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [9:0] instr = '0;
    logic       data_valid = 1'b0;
    logic       instr_ready, data_ack, rf_we, rf_rae, rf_rbe, done, illegal;
    logic [1:0] rf_wa, rf_raa, rf_rba, wsel;
    logic [2:0] alu_op;
    logic [9:0] imm;

    cpu_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .data_valid(data_valid), .data_ack(data_ack),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_rae(rf_rae), .rf_rbe(rf_rbe),
        .rf_raa(rf_raa), .rf_rba(rf_rba), .alu_op(alu_op), .wsel(wsel),
        .imm(imm), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef CPU_CTRL_FAST_MOV_EN
    localparam int MOV_W = 1;
`else
    localparam int MOV_W = 3;
`endif

    typedef struct packed {
        logic       ready;
        logic       we;
        logic [1:0] wa;
        logic       rae;
        logic       rbe;
        logic [1:0] raa;
        logic [1:0] rba;
        logic [2:0] alu;
        logic [1:0] wsel;
        logic [9:0] imm;
        logic       ack;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [9:0] instr;
        int         dv_low;
        logic       hold;
        int         we_cyc;
        int         wa;
        int         wsel;
        int         alu;
        int         imm;
        int         ack;
        int         ill_cyc;
    } vec_t;

    outs_t act;
    assign act = {instr_ready, rf_we, rf_wa, rf_rae, rf_rbe, rf_raa, rf_rba,
                  alu_op, wsel, imm, data_ack, done, illegal};

    int checks = 0;
    int errors = 0;

    // Reference model: position within the instruction, counted in cycles since accept.
    bit         m_busy = 1'b0;
    logic [9:0] m_cur = '0;
    int         m_k = 0;
    int         dut_acc = 0;

    function automatic outs_t model_out(bit busy, logic [9:0] cur, int k, logic dv);
        outs_t      e;
        logic [2:0] op;
        logic [1:0] rx, ry;
        e  = '0;
        op = cur[9:7];
        rx = cur[6:5];
        ry = cur[4:3];
        if (!busy) begin
            e.ready = 1'b1;
            return e;
        end
        if (k == 0) begin
            e.illegal = (op == 3'd7);
            return e;
        end
        if (op == 3'd0) begin
            e.wsel = 2'b01;
            if (dv) begin
                e.we = 1'b1; e.wa = rx; e.ack = 1'b1; e.done = 1'b1;
            end
        end else if (op == 3'd6) begin
            if (k == 1) begin
                e.we = 1'b1; e.wa = rx; e.done = 1'b1;
                e.wsel = 2'b10; e.imm = {7'd0, cur[2:0]};
            end
        end else if (op == 3'd1) begin
            if (k <= MOV_W) begin
                e.rbe = 1'b1; e.rba = ry; e.alu = 3'd0;
                if (k == MOV_W) begin
                    e.we = 1'b1; e.wa = rx; e.done = 1'b1;
                end
            end
        end else begin
            if (k <= 3) begin
                e.rae = 1'b1; e.raa = rx; e.rbe = 1'b1; e.rba = ry;
                e.alu = op - 3'd1;
                if (k == 3) begin
                    e.we = 1'b1; e.wa = rx; e.done = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic check_vec(input string name, input outs_t a, input outs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, a, e);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic iv, input logic [9:0] in, input logic dv,
                        input string tag, output outs_t seen);
        outs_t e;
        instr_valid = iv;
        instr       = in;
        data_valid  = dv;
        #1;
        e    = model_out(m_busy, m_cur, m_k, dv);
        seen = act;
        check_vec(tag, act, e);
        if (instr_ready && iv) dut_acc++;
        @(posedge clk);
        if (!m_busy) begin
            if (iv) begin
                m_busy = 1'b1; m_cur = in; m_k = 0;
            end
        end else if (e.done || e.illegal) begin
            m_busy = 1'b0;
        end else begin
            m_k++;
        end
        @(negedge clk);
    endtask

    task automatic reset_hit(input string tag);
        outs_t rv;
        rv = model_out(1'b0, '0, 0, 1'b0);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_vec({tag, " reset now"}, act, rv);
        m_busy = 1'b0;
        @(posedge clk);
        #1;
        check_vec({tag, " reset held"}, act, rv);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [9:0] in, input int dv_low, input logic hold,
                             output int we_cyc, output outs_t we_vec,
                             output int ill_cyc, output int acc);
        outs_t s;
        int    cyc;
        int    acc0;
        we_cyc  = -1;
        ill_cyc = -1;
        we_vec  = '0;
        acc0    = dut_acc;
        step(1'b1, in, 1'b0, $sformatf("accept %h", in), s);
        cyc = 0;
        while (m_busy && cyc < dv_low + 12) begin
            step(hold, in, (cyc > dv_low), $sformatf("instr %h cycle %0d", in, cyc), s);
            if (s.we) begin
                if (we_cyc < 0) begin
                    we_cyc = cyc;
                    we_vec = s;
                end else begin
                    we_cyc = 99;
                end
            end
            if (s.illegal) ill_cyc = cyc;
            cyc++;
        end
        acc = dut_acc - acc0;
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL retire %h: actual busy required idle within %0d cycles", in, dv_low + 12);
            reset_hit("timeout");
        end
    endtask

    vec_t vecs[12];

    initial begin
        outs_t s;
        outs_t wv;
        int    wc, ic, ac;

        vecs = '{
            '{10'b110_01_00_101, 0, 1'b0, 1,     1, 2, 0, 5, 0, -1}, // LDI R1,#5
            '{10'b110_10_00_011, 0, 1'b0, 1,     2, 2, 0, 3, 0, -1}, // LDI R2,#3
            '{10'b010_01_10_000, 0, 1'b0, 3,     1, 0, 1, 0, 0, -1}, // ADD R1,R2
            '{10'b110_11_00_111, 0, 1'b0, 1,     3, 2, 0, 7, 0, -1}, // LDI R3,#7
            '{10'b000_00_00_000, 4, 1'b0, 5,     0, 1, 0, 0, 1, -1}, // LOAD R0, data late
            '{10'b111_01_10_101, 0, 1'b1, -1,    0, 0, 0, 0, 0, 0},  // reserved, valid held
            '{10'b001_00_11_000, 0, 1'b0, MOV_W, 0, 0, 0, 0, 0, -1}, // MOV R0,R3
            '{10'b011_10_10_000, 0, 1'b0, 3,     2, 0, 2, 0, 0, -1}, // SUB R2,R2
            '{10'b100_11_00_000, 0, 1'b0, 3,     3, 0, 3, 0, 0, -1}, // AND R3,R0
            '{10'b101_01_11_000, 0, 1'b0, 3,     1, 0, 4, 0, 0, -1}, // OR R1,R3
            '{10'b000_10_01_110, 0, 1'b0, 1,     2, 1, 0, 0, 1, -1}, // LOAD R2, data ready
            '{10'b010_00_00_000, 0, 1'b1, 3,     0, 0, 1, 0, 0, -1}  // ADD R0,R0, valid held
        };

        @(negedge clk);
        #1;
        check_vec("reset values", act, model_out(1'b0, '0, 0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].dv_low, vecs[i].hold, wc, wv, ic, ac);
            check_int($sformatf("v%0d write cycle", i), wc, vecs[i].we_cyc);
            check_int($sformatf("v%0d illegal cycle", i), ic, vecs[i].ill_cyc);
            check_int($sformatf("v%0d accepts", i), ac, 1);
            if (vecs[i].we_cyc >= 0) begin
                check_int($sformatf("v%0d wa", i), int'(wv.wa), vecs[i].wa);
                check_int($sformatf("v%0d wsel", i), int'(wv.wsel), vecs[i].wsel);
                check_int($sformatf("v%0d alu_op", i), int'(wv.alu), vecs[i].alu);
                check_int($sformatf("v%0d imm", i), int'(wv.imm), vecs[i].imm);
                check_int($sformatf("v%0d data_ack", i), int'(wv.ack), vecs[i].ack);
                check_int($sformatf("v%0d done", i), int'(wv.done), 1);
            end
            step(1'b0, '0, 1'b0, $sformatf("v%0d ready after", i), s);
        end

        // Reset landing in EX of SUB R2,R1 must abort without a write.
        step(1'b1, 10'b011_10_01_000, 1'b0, "sub accept", s);
        step(1'b0, '0, 1'b0, "sub cycle 0", s);
        step(1'b0, '0, 1'b0, "sub cycle 1", s);
        instr_valid = 1'b0;
        #1;
        check_vec("sub EX", act, model_out(m_busy, m_cur, m_k, 1'b0));
        reset_hit("sub EX");
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b0, $sformatf("after abort %0d", i), s);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_hit($sformatf("rand %0d", n));
            end else begin
                step(($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
                     ($urandom_range(0, 2) == 0), $sformatf("rand %0d", n), s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Multi-cycle control sequencer for the 10-bit CPU datapath. It accepts one 10-bit instruction at a time over a valid/ready handshake, decodes it, and drives the register file's write port, two read-port enables and addresses, the ALU operation select, and the write-data source select. It sits between instruction fetch and the 4×10-bit register file / ALU datapath, and is the only master of the register file control pins.

## Interface
- No parameters. Widths are fixed: 10-bit data, 2-bit register address, 3-bit ALU op.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word on `instr` is valid
- instr  in  10  instruction word: [9:7] op, [6:5] rx, [4:3] ry, [2:0] imm3
- instr_ready  out  1  sequencer can accept an instruction
- data_valid  in  1  external load data is present on the datapath bus
- data_ack  out  1  external load data consumed this cycle
- rf_we  out  1  register file write enable
- rf_wa  out  2  register file write address
- rf_rae, rf_rbe  out  1 each  read port A / B enables
- rf_raa, rf_rba  out  2 each  read port A / B addresses
- alu_op  out  3  ALU operation: 000 PASS_B, 001 ADD, 010 SUB, 011 AND, 100 OR
- wsel  out  2  write-data source: 00 ALU result, 01 external data, 10 immediate
- imm  out  10  zero-extended immediate, {7'b0, imm3}
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  one-cycle pulse: reserved opcode dropped

## Operation
- Opcodes:
  - 000 LOAD: Rx ← external data
  - 001 MOV: Rx ← Ry
  - 010 ADD: Rx ← Rx + Ry
  - 011 SUB: Rx ← Rx − Ry
  - 100 AND: Rx ← Rx & Ry
  - 101 OR: Rx ← Rx | Ry
  - 110 LDI: Rx ← imm
  - 111 reserved
- Instruction handling:
  - The instruction is latched on the edge where instr_valid & instr_ready are both high.
  - instr_ready = 1 only in IDLE.
- States:
  - IDLE: waits for the handshake, then goes to DEC.
  - DEC: reserved op → pulse illegal, go to IDLE. LOAD → WAITD. LDI → WR. MOV/ALU ops → RD.
  - RD: go to EX.
  - EX: go to WR.
  - WAITD: when data_valid = 1, assert rf_we, data_ack, done and wsel = 01 in the same cycle, then go to IDLE. Otherwise stay in WAITD indefinitely.
  - WR: assert rf_we and done, go to IDLE.
- Read ports:
  - ALU ops: rf_rae = 1 with rf_raa = rx, and rf_rbe = 1 with rf_rba = ry, held through RD, EX and WR.
  - MOV: only port B is used (rf_rbe = 1, rf_rba = ry), alu_op = PASS_B.
- Output drive rules:
  - rf_wa = rx whenever rf_we = 1.
  - In IDLE and DEC all enables are 0 and addresses are 0.
  - All outputs are decoded from the state register and the latched instruction only. The exceptions are rf_we, data_ack and done in WAITD, which are gated by data_valid.
- rx == ry is legal; e.g. SUB R2,R2 writes 0.
- Writes to any register, including R0, are permitted.
- Arithmetic is the ALU's responsibility. The sequencer does not see data values and ignores overflow.

## Timing
- Cycle 0 is the cycle after the accept edge.
- Write cycle per instruction class (write commits at the end of that cycle):
  - ALU ops and MOV: WR in cycle 3.
  - LDI: WR in cycle 1.
  - LOAD: write in the first WAITD cycle (cycle ≥ 1) with data_valid = 1.
- instr_ready returns to 1 the cycle after done, so at most one instruction is in flight.
- illegal pulses in cycle 0; instr_ready = 1 again in cycle 1.
- Reset (async, any state):
  - State returns to IDLE immediately.
  - Reset values: instr_ready = 1; rf_we, data_ack, rf_rae, rf_rbe, done, illegal = 0; all addresses, alu_op, wsel, imm = 0.
  - No write completes if reset asserts mid-instruction.
- instr_valid while busy is ignored; the source must hold it until ready.

## Configuration
- CPU_CTRL_FAST_MOV_EN defined: MOV goes DEC → WR directly, with rf_rbe/rf_rba and alu_op held in WR. Write occurs in cycle 1. This is legal because register file reads are asynchronous.
- Undefined: MOV takes the full RD/EX/WR path, writing in cycle 3.

## Test plan
- Reset: preload R1 = 10'h005 and R2 = 10'h003 via LDI, then ADD R1,R2 (10'b010_01_10_000). Expect rae/raa = 1, rbe/rba = 2, alu_op = 001 in cycles 1–3; rf_we, wa = 1, done in cycle 3; ready in cycle 4.
- LDI R3,#7 (10'b110_11_00_111): imm = 10'h007, wsel = 10, rf_we with wa = 3 in cycle 1; done single pulse.
- LOAD R0 with data_valid held low for 4 cycles, then high: no rf_we while low; rf_we, data_ack, done and wsel = 01 in the same cycle data_valid rises.
- Opcode 111 → illegal pulse in cycle 0, no rf_we at any time, instr_ready = 1 in cycle 1. Assert instr_valid continuously while busy and check that only one accept occurs per instruction.
- Assert rst_n low during EX of SUB R2,R1: outputs go to reset values immediately; no rf_we is ever asserted for that instruction.
- MOV R0,R3: rf_we in cycle 1 with CPU_CTRL_FAST_MOV_EN defined, cycle 3 without. In both cases rbe = 1, rba = 3, alu_op = 000.
